// File: rtl/master_spi_controller.sv
`timescale 1ns/1ps
// master_spi_controller
//   SPI master, one word per transfer, MSB first, configurable CPOL/CPHA.
//   Frame: IDLE -> SETUP (cs low, MSB on mosi0) -> TRANSFER (2*DATA_WIDTH
//   sclk toggles) -> HOLD (cs still low) -> IDLE (rx_data loaded, rx_valid).
//
// Parameters
//   DATA_WIDTH : bits per transfer (2..32)
//   BAUD_DIV   : pclk cycles per sclk half-period (1..255)
//   CPOL       : sclk idle level
//   CPHA       : 0 = sample on leading edge, 1 = sample on trailing edge
//
// Ports
//   pclk     : clock, rising edge
//   areset   : asynchronous active-low reset
//   start    : transfer request, honoured only while ready=1
//   tx_data  : word to send
//   ready    : controller idle, start will be accepted
//   rx_data  : last received word
//   rx_valid : one-cycle pulse when rx_data updates
//   sclk     : serial clock
//   cs       : active-low slave select
//   mosi0    : serial data out
//   miso0    : serial data in
module master_spi_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi0,
    input  logic                  miso0
);

    localparam int DIV_W = $clog2(BAUD_DIV + 1);
    localparam int BIT_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD
    } state_t;

    state_t                  r_state;
    state_t                  r_state_next;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_tx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic                    r_sclk;
    logic                    r_cs;

    logic w_div_last;
    logic w_accept;
    logic w_edge;
    logic w_leading;
    logic w_trailing;
    logic w_sample;
    logic w_shift;
    logic w_finish;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        w_div_last   = (r_div_cnt == DIV_LAST);
        w_accept     = 1'b0;
        w_edge       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    r_state_next = SETUP;
                end
            end
            SETUP: begin
                if (w_div_last) begin
                    r_state_next = TRANSFER;
                end
            end
            TRANSFER: begin
                if (w_div_last) begin
                    w_edge = 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        r_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_div_last) begin
                    w_finish     = 1'b1;
                    r_state_next = IDLE;
                end
            end
            default: r_state_next = IDLE;
        endcase

        // Even toggle index = leading edge, odd = trailing edge.
        w_leading  = w_edge && !r_bit_cnt[0];
        w_trailing = w_edge &&  r_bit_cnt[0];
        if (CPHA) begin
            w_sample = w_trailing;
            // First leading edge keeps the MSB presented during SETUP.
            w_shift  = w_leading && (r_bit_cnt != '0);
        end else begin
            w_sample = w_leading;
            // No shift after the final sample; mosi0 holds the LSB into HOLD.
            w_shift  = w_trailing && (r_bit_cnt != BIT_LAST);
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= CPOL;
            r_cs       <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;

            if (r_state == IDLE) begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
            end else begin
                r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
            end

            if (w_accept) begin
                r_tx_shift <= tx_data;
                r_cs       <= 1'b0;
            end

            if (w_edge) begin
                r_sclk    <= ~r_sclk;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], miso0};
            end

            if (w_finish) begin
                r_cs       <= 1'b1;
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end
        end
    end

    assign ready    = (r_state == IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign sclk     = r_sclk;
    assign cs       = r_cs;
    assign mosi0    = r_tx_shift[DATA_WIDTH-1];

endmodule

// File: tb/tb_master_spi_controller.sv
`timescale 1ns/1ps
module tb_master_spi_controller;

    logic pclk;
    logic areset;

    // Instance A: mode 0, 8 bits, BAUD_DIV=2
    logic       start_a, ready_a, rxv_a, sclk_a, cs_a, mosi_a, miso_a;
    logic [7:0] tx_a, rx_a, a_pat;
    // Instance B: mode 3, 8 bits, BAUD_DIV=2
    logic       start_b, ready_b, rxv_b, sclk_b, cs_b, mosi_b, miso_b;
    logic [7:0] tx_b, rx_b;
    // Instance C: mode 0, 2 bits, BAUD_DIV=1
    logic       start_c, ready_c, rxv_c, sclk_c, cs_c, mosi_c, miso_c;
    logic [1:0] tx_c, rx_c, c_pat;

    int n_checks;
    int n_fail;

    master_spi_controller #(.DATA_WIDTH(8), .BAUD_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_a (
        .pclk(pclk), .areset(areset), .start(start_a), .tx_data(tx_a), .ready(ready_a),
        .rx_data(rx_a), .rx_valid(rxv_a), .sclk(sclk_a), .cs(cs_a), .mosi0(mosi_a), .miso0(miso_a)
    );

    master_spi_controller #(.DATA_WIDTH(8), .BAUD_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u_b (
        .pclk(pclk), .areset(areset), .start(start_b), .tx_data(tx_b), .ready(ready_b),
        .rx_data(rx_b), .rx_valid(rxv_b), .sclk(sclk_b), .cs(cs_b), .mosi0(mosi_b), .miso0(miso_b)
    );

    master_spi_controller #(.DATA_WIDTH(2), .BAUD_DIV(1), .CPOL(1'b0), .CPHA(1'b0)) u_c (
        .pclk(pclk), .areset(areset), .start(start_c), .tx_data(tx_c), .ready(ready_c),
        .rx_data(rx_c), .rx_valid(rxv_c), .sclk(sclk_c), .cs(cs_c), .mosi0(mosi_c), .miso0(miso_c)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Mode-0 slave for A: MSB on cs fall, next bit after each rising sclk.
    initial begin : slave_a
        int idx;
        miso_a = 1'b0;
        forever begin
            @(negedge cs_a);
            idx = 7;
            miso_a = a_pat[idx];
            while (cs_a == 1'b0) begin
                @(posedge sclk_a or posedge cs_a);
                if (cs_a == 1'b0 && idx > 0) begin
                    idx--;
                    miso_a = a_pat[idx];
                end
            end
        end
    end

    // Mode-0 slave for C.
    initial begin : slave_c
        int idx;
        miso_c = 1'b0;
        forever begin
            @(negedge cs_c);
            idx = 1;
            miso_c = c_pat[idx];
            while (cs_c == 1'b0) begin
                @(posedge sclk_c or posedge cs_c);
                if (cs_c == 1'b0 && idx > 0) begin
                    idx--;
                    miso_c = c_pat[idx];
                end
            end
        end
    end

    initial begin
        miso_b = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One frame on A; called at a negedge, returns at a negedge 80 cycles later.
    task automatic xfer_a(input logic [7:0] tx, input logic [7:0] pat, input int inj,
                          output logic [7:0] bits, output int lat, output int csl,
                          output int ml, output int nv, output logic cs1);
        logic prev;
        bits = '0; lat = 0; csl = 0; ml = 0; nv = 0; cs1 = 1'b1;
        tx_a = tx;
        a_pat = pat;
        start_a = 1'b1;
        prev = sclk_a;
        @(posedge pclk);
        for (int n = 1; n <= 80; n++) begin
            @(negedge pclk);
            if (n == 1) cs1 = cs_a;
            if (!cs_a) csl++;
            if (!cs_a && !mosi_a) ml++;
            if (sclk_a && !prev) bits = {bits[6:0], mosi_a};
            prev = sclk_a;
            if (rxv_a) begin
                nv++;
                if (lat == 0) lat = n;
            end
            if (n == 1) start_a = 1'b0;
            if (inj != 0 && n == inj) begin
                tx_a = 8'h00;
                start_a = 1'b1;
            end
            if (inj != 0 && n == inj + 1) start_a = 1'b0;
        end
    endtask

    task automatic test_reset;
        areset = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        tx_a = '0; tx_b = '0; tx_c = '0; a_pat = '0; c_pat = '0;
        repeat (3) @(negedge pclk);
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
        n_checks++; if (cs_a !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b expected 1", cs_a); end
        n_checks++; if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL reset_sclk_a: got %b expected 0", sclk_a); end
        n_checks++; if (sclk_b !== 1'b1) begin n_fail++; $display("FAIL reset_sclk_b: got %b expected 1", sclk_b); end
        n_checks++; if (mosi_a !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", mosi_a); end
        n_checks++; if (rxv_a !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rxv_a); end
        n_checks++; if (rx_a !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_a); end
        areset = 1'b1;
    endtask

    // Starts right at reset release: the first edge must accept it.
    task automatic test_mode0;
        logic [7:0] bits; int lat, csl, ml, nv; logic cs1;
        xfer_a(8'hA5, 8'h3C, 0, bits, lat, csl, ml, nv, cs1);
        n_checks++; if (cs1 !== 1'b0) begin n_fail++; $display("FAIL m0_first_accept: cs got %b expected 0", cs1); end
        n_checks++; if (bits !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi: got %h expected a5", bits); end
        n_checks++; if (rx_a !== 8'h3C) begin n_fail++; $display("FAIL m0_rx_data: got %h expected 3c", rx_a); end
        n_checks++; if (lat != 37) begin n_fail++; $display("FAIL m0_latency: got %0d expected 37", lat); end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL m0_valid_count: got %0d expected 1", nv); end
        n_checks++; if (csl != 36) begin n_fail++; $display("FAIL m0_cs_low: got %0d expected 36", csl); end
    endtask

    task automatic test_mode3;
        logic [7:0] bits; int tog, csl, lat; logic prev;
        bits = '0; tog = 0; csl = 0; lat = 0;
        n_checks++; if (sclk_b !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sclk: got %b expected 1", sclk_b); end
        n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL m3_ready: got %b expected 1", ready_b); end
        tx_b = 8'h81;
        start_b = 1'b1;
        prev = sclk_b;
        @(posedge pclk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge pclk);
            if (!cs_b) csl++;
            if (sclk_b != prev) begin
                tog++;
                if (sclk_b) bits = {bits[6:0], mosi_b};
            end
            prev = sclk_b;
            if (rxv_b && lat == 0) lat = n;
            if (n == 1) start_b = 1'b0;
        end
        n_checks++; if (tog != 16) begin n_fail++; $display("FAIL m3_toggles: got %0d expected 16", tog); end
        n_checks++; if (csl != 36) begin n_fail++; $display("FAIL m3_cs_low: got %0d expected 36", csl); end
        n_checks++; if (bits !== 8'h81) begin n_fail++; $display("FAIL m3_mosi: got %h expected 81", bits); end
        n_checks++; if (rx_b !== 8'hFF) begin n_fail++; $display("FAIL m3_rx_data: got %h expected ff", rx_b); end
        n_checks++; if (lat != 37) begin n_fail++; $display("FAIL m3_latency: got %0d expected 37", lat); end
        n_checks++; if (sclk_b !== 1'b1) begin n_fail++; $display("FAIL m3_end_sclk: got %b expected 1", sclk_b); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bits0, bits1, rx1, rx2; int frames, csh, lat2; logic prev;
        bits0 = '0; bits1 = '0; rx1 = '0; rx2 = '0; frames = 0; csh = 0; lat2 = 0;
        tx_a = 8'h12;
        a_pat = 8'h6B;
        start_a = 1'b1;
        prev = sclk_a;
        @(posedge pclk);
        for (int n = 1; n <= 120; n++) begin
            @(negedge pclk);
            if (rxv_a) begin
                frames++;
                if (frames == 1) rx1 = rx_a;
                else begin
                    rx2 = rx_a;
                    lat2 = n;
                end
            end
            if (sclk_a && !prev) begin
                if (frames == 0) bits0 = {bits0[6:0], mosi_a};
                else bits1 = {bits1[6:0], mosi_a};
            end
            prev = sclk_a;
            if (frames == 1 && cs_a) csh++;
            if (n == 1) tx_a = 8'h34;
            if (frames == 1 && !cs_a) start_a = 1'b0;
        end
        start_a = 1'b0;
        n_checks++; if (frames != 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", frames); end
        n_checks++; if (csh != 1) begin n_fail++; $display("FAIL b2b_cs_high: got %0d expected 1", csh); end
        n_checks++; if (bits0 !== 8'h12) begin n_fail++; $display("FAIL b2b_mosi0: got %h expected 12", bits0); end
        n_checks++; if (bits1 !== 8'h34) begin n_fail++; $display("FAIL b2b_mosi1: got %h expected 34", bits1); end
        n_checks++; if (rx1 !== 8'h6B) begin n_fail++; $display("FAIL b2b_rx1: got %h expected 6b", rx1); end
        n_checks++; if (rx2 !== 8'h6B) begin n_fail++; $display("FAIL b2b_rx2: got %h expected 6b", rx2); end
        n_checks++; if (lat2 != 74) begin n_fail++; $display("FAIL b2b_latency2: got %0d expected 74", lat2); end
    endtask

    task automatic test_busy_start;
        logic [7:0] bits; int lat, csl, ml, nv; logic cs1;
        xfer_a(8'hFF, 8'h0F, 10, bits, lat, csl, ml, nv, cs1);
        n_checks++; if (ml != 0) begin n_fail++; $display("FAIL busy_mosi_low: got %0d cycles expected 0", ml); end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL busy_valid_count: got %0d expected 1", nv); end
        n_checks++; if (bits !== 8'hFF) begin n_fail++; $display("FAIL busy_mosi: got %h expected ff", bits); end
        n_checks++; if (rx_a !== 8'h0F) begin n_fail++; $display("FAIL busy_rx_data: got %h expected 0f", rx_a); end
        n_checks++; if (lat != 37) begin n_fail++; $display("FAIL busy_latency: got %0d expected 37", lat); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] bits; int lat, csl, ml, nv, tog, rv; logic cs1, prev;
        tog = 0; rv = 0;
        tx_a = 8'hC3;
        a_pat = 8'h99;
        start_a = 1'b1;
        prev = sclk_a;
        @(posedge pclk);
        for (int n = 1; n <= 40 && tog < 3; n++) begin
            @(negedge pclk);
            if (sclk_a != prev) tog++;
            prev = sclk_a;
            if (n == 1) start_a = 1'b0;
        end
        n_checks++; if (tog != 3) begin n_fail++; $display("FAIL rmid_reach_toggle3: got %0d expected 3", tog); end
        areset = 1'b0;
        #1;
        n_checks++; if (cs_a !== 1'b1) begin n_fail++; $display("FAIL rmid_cs: got %b expected 1", cs_a); end
        n_checks++; if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL rmid_sclk: got %b expected 0", sclk_a); end
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", ready_a); end
        n_checks++; if (rx_a !== 8'h00) begin n_fail++; $display("FAIL rmid_rx_data: got %h expected 00", rx_a); end
        repeat (2) begin
            @(negedge pclk);
            if (rxv_a) rv++;
        end
        n_checks++; if (rv != 0) begin n_fail++; $display("FAIL rmid_no_valid: got %0d pulses expected 0", rv); end
        areset = 1'b1;
        xfer_a(8'h5A, 8'hE7, 0, bits, lat, csl, ml, nv, cs1);
        n_checks++; if (cs1 !== 1'b0) begin n_fail++; $display("FAIL rmid_first_accept: cs got %b expected 0", cs1); end
        n_checks++; if (bits !== 8'h5A) begin n_fail++; $display("FAIL rmid_next_mosi: got %h expected 5a", bits); end
        n_checks++; if (rx_a !== 8'hE7) begin n_fail++; $display("FAIL rmid_next_rx: got %h expected e7", rx_a); end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL rmid_next_valid_count: got %0d expected 1", nv); end
        n_checks++; if (lat != 37) begin n_fail++; $display("FAIL rmid_next_latency: got %0d expected 37", lat); end
    endtask

    task automatic test_min_div;
        logic [1:0] bits; int tog, csl, lat, last_t, gap_bad; logic prev;
        bits = '0; tog = 0; csl = 0; lat = 0; last_t = 0; gap_bad = 0;
        n_checks++; if (ready_c !== 1'b1) begin n_fail++; $display("FAIL div1_ready: got %b expected 1", ready_c); end
        tx_c = 2'b10;
        c_pat = 2'b01;
        start_c = 1'b1;
        prev = sclk_c;
        @(posedge pclk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge pclk);
            if (!cs_c) csl++;
            if (sclk_c != prev) begin
                tog++;
                if (last_t != 0 && n - last_t != 1) gap_bad++;
                last_t = n;
                if (sclk_c) bits = {bits[0], mosi_c};
            end
            prev = sclk_c;
            if (rxv_c && lat == 0) lat = n;
            if (n == 1) start_c = 1'b0;
        end
        n_checks++; if (tog != 4) begin n_fail++; $display("FAIL div1_toggles: got %0d expected 4", tog); end
        n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL div1_half_period: got %0d bad gaps expected 0", gap_bad); end
        n_checks++; if (csl != 6) begin n_fail++; $display("FAIL div1_cs_low: got %0d expected 6", csl); end
        n_checks++; if (bits !== 2'b10) begin n_fail++; $display("FAIL div1_mosi: got %b expected 10", bits); end
        n_checks++; if (rx_c !== 2'b01) begin n_fail++; $display("FAIL div1_rx_data: got %b expected 01", rx_c); end
        n_checks++; if (lat != 7) begin n_fail++; $display("FAIL div1_latency: got %0d expected 7", lat); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_busy_start();
        test_reset_mid();
        test_min_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/master_spi_controller.md
MASTER_SPI_CONTROLLER -- requirements
Module: master_spi_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per transfer, legal range 2..32.
REQ-002 SHALL have parameter BAUD_DIV, default 2: pclk cycles per sclk half-period, legal range 1..255.
REQ-003 SHALL have parameter CPOL, default 0: sclk idle level.
REQ-004 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have port pclk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 SHALL have port areset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: transfer request, sampled only while ready=1.
REQ-008 SHALL have port tx_data, input, DATA_WIDTH bits: word to send, MSB first.
REQ-009 SHALL have port ready, output, 1 bit: controller is in IDLE and can accept start.
REQ-010 SHALL have port rx_data, output, DATA_WIDTH bits: last word received on miso0.
REQ-011 SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking rx_data as updated.
REQ-012 SHALL have port sclk, output, 1 bit: serial clock.
REQ-013 SHALL have port cs, output, 1 bit: active-low slave select.
REQ-014 SHALL have port mosi0, output, 1 bit: master-out serial data.
REQ-015 SHALL have port miso0, input, 1 bit: master-in serial data.

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, TRANSFER and HOLD.
REQ-017 In IDLE with start=1, the block SHALL latch tx_data into the shift register and move to SETUP on the next edge.
REQ-018 In IDLE, start=0 SHALL leave the FSM in IDLE.
REQ-019 ready SHALL be 1 only in IDLE, and start SHALL be ignored in every other state.
REQ-020 On SETUP entry, cs SHALL go to 0 and mosi0 SHALL equal tx_data[DATA_WIDTH-1].
REQ-021 sclk SHALL stay at CPOL during SETUP.
REQ-022 SETUP SHALL last BAUD_DIV cycles.
REQ-023 During TRANSFER, sclk SHALL toggle every BAUD_DIV cycles, giving exactly 2*DATA_WIDTH toggles, so TRANSFER lasts 2*DATA_WIDTH*BAUD_DIV cycles.
REQ-024 At the end of TRANSFER, sclk SHALL be back at CPOL.
REQ-025 CPHA=0: miso0 SHALL be sampled into the receive register on each leading edge, and mosi0 SHALL advance to the next bit on each trailing edge except the last.
REQ-026 CPHA=1: mosi0 SHALL advance on each leading edge except the first (MSB stays from SETUP), and miso0 SHALL be sampled on each trailing edge.
REQ-027 The receive register SHALL shift in MSB first, so the first sampled bit ends as rx_data[DATA_WIDTH-1].
REQ-028 HOLD SHALL keep cs=0 and sclk=CPOL for BAUD_DIV cycles, then return to IDLE.
REQ-029 On the HOLD->IDLE transition, cs SHALL go to 1, rx_data SHALL load the receive register, and rx_valid SHALL be 1 for exactly the first IDLE cycle.
REQ-030 A start in that first IDLE cycle SHALL be accepted (back-to-back), giving a minimum cs-high time of 1 pclk.
REQ-031 Start-to-rx_valid latency SHALL be 1 + BAUD_DIV*(2*DATA_WIDTH+2) cycles, measured from the start-sampling edge.
REQ-032 The half-period counter SHALL be ceil(log2(BAUD_DIV+1)) bits and the bit counter ceil(log2(2*DATA_WIDTH+1)) bits, neither of which may wrap within a state.
REQ-033 rx_data SHALL hold its value between transfers.
REQ-034 tx_data changes after acceptance SHALL NOT affect the transfer in progress.

Reset
REQ-035 areset=0 SHALL asynchronously force: FSM to IDLE, ready=1, cs=1, sclk=CPOL, mosi0=0, rx_valid=0, rx_data=0, and all counters to 0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no rx_valid pulse.
REQ-037 The first start SHALL be accepted on the first rising pclk edge after areset deasserts.

Verification
REQ-038 Mode 0: DATA_WIDTH=8, BAUD_DIV=2, tx_data=0xA5, slave returns 0x3C -> mosi0 shows 1,0,1,0,0,1,0,1 at leading edges, rx_data=0x3C, rx_valid pulses once 37 cycles after start.
REQ-039 Mode 3: CPOL=1, CPHA=1, tx_data=0x81, miso0 fixed at 1 -> sclk idles high, 16 toggles occur, rx_data=0xFF, cs low for 36 cycles.
REQ-040 Back-to-back: start held at 1 with tx_data 0x12 then 0x34 -> cs high for exactly 1 cycle between frames, two rx_valid pulses, 0x34 not corrupted.
REQ-041 Busy start: start pulse with tx_data=0x00 during TRANSFER of 0xFF -> ignored, mosi0 stays 1 throughout, only one rx_valid.
REQ-042 Reset mid-transfer: areset=0 after the 3rd sclk toggle -> cs=1, sclk=CPOL, ready=1 immediately, no rx_valid, rx_data=0; the next transfer is correct.
REQ-043 BAUD_DIV=1, DATA_WIDTH=2: tx_data=2'b10, miso0 returns 2'b01 -> sclk period 2 pclk, rx_data=2'b01, latency 7 cycles.
